alu_multicycle: RTL and testbench
=================================

// Module: alu_multicycle
// PURPOSE
//   Parametrised successor to the single-cycle execute ALU. Logic and shift ops
//   finish in one cycle; MUL and unsigned DIV/REM run iteratively.
//   valid/ready handshakes on both sides let the EX stage stall on long ops.
//   zero_o is registered alongside the result; branch compare uses it.
// PARAMETERS
//   WIDTH   32  operand/result width; power of two, >= 8
//   CTRL_W  4   width of ALUCtrl_i
//   SHW     $clog2(WIDTH)  localparam: shift-amount bits
// PORTS
//   clk_i      in   1       clock, all state updates on rising edge
//   rst_i      in   1       asynchronous, active-low reset
//   flush_i    in   1       synchronous abort of the op in flight / held result
//   valid_i    in   1       request valid
//   ready_o    out  1       block accepts request this cycle
//   data1_i    in   WIDTH   operand A
//   data2_i    in   WIDTH   operand B
//   ALUCtrl_i  in   CTRL_W  opcode, captured on acceptance
//   valid_o    out  1       result valid; held until consumed
//   ready_i    in   1       consumer accepts result
//   data_o     out  WIDTH   result, stable while valid_o=1
//   Zero_o     out  1       1 iff captured data1_i == data2_i
// BEHAVIOUR
//   Reset (rst_i=0, asynchronous): state=IDLE, valid_o=0, data_o=0, Zero_o=0,
//     counter and iteration registers cleared. ready_o=1 once reset releases.
//   Opcodes: 0000 ADD, 0001 SUB, 0010 MUL (low WIDTH bits), 0011 AND,
//     0100 OR, 0101 XOR, 0110 SLL, 0111 SRL, 1000 SRA, 1001 DIVU, 1010 REMU.
//     Any other code executes ADD.
//   Shifts use data2_i[SHW-1:0] only. Add, sub and mul wrap modulo 2^WIDTH.
//   Acceptance: an edge where valid_i && ready_o. Operands and opcode are
//     captured; the inputs are don't-care afterwards.
//   ready_o = (state==IDLE) || (state==DONE && ready_i), combinational.
//   States and transitions:
//     IDLE -> DONE : single-cycle op accepted; valid_o=1 on the next edge.
//     IDLE -> BUSY : MUL/DIVU/REMU accepted; counter loads WIDTH.
//     BUSY         : one shift-add (MUL) or restoring step (DIV) per cycle;
//                    counter decrements.
//     BUSY -> DONE : when counter reaches 0. valid_o rises exactly WIDTH+1
//                    edges after the acceptance edge.
//     DONE         : data_o and Zero_o hold stable.
//     DONE -> IDLE : on ready_i with no new accept.
//     DONE -> DONE/BUSY : ready_i && valid_i consumes the result and accepts
//                    the next op on the same edge (back-to-back, no bubble).
//   Divide by zero: DIVU returns all ones; REMU returns the dividend. Either
//     takes the full WIDTH+1 latency.
//   flush_i=1: the next state is IDLE, valid_o=0, and no request is accepted
//     that cycle (ready_o=0). flush_i has priority over ready_i/valid_i.
//   Reset mid-BUSY: the op is discarded; no valid_o follows.
//   valid_o must never drop without ready_i or flush_i. data_o must never
//     change while valid_o=1.
// TESTING (WIDTH=32)
//   1. ADD 5,7 accepted -> next edge valid_o=1, data_o=12, Zero_o=0;
//      SUB 9,9 -> data_o=0, Zero_o=1.
//   2. MUL 0x0000FFFF,0x00010001 -> data_o=0xFFFFFFFF with valid_o exactly
//      33 edges after accept; ready_o=0 throughout BUSY.
//   3. DIVU 100,7 -> 14; REMU 100,7 -> 2; DIVU 9,0 -> 0xFFFFFFFF;
//      REMU 9,0 -> 9.
//   4. ready_i held low for 5 cycles in DONE -> data_o stable, ready_o=0.
//      Then ready_i=1 with valid_i (ADD 1,1) -> consumed and accepted on the
//      same edge; next edge data_o=2.
//   5. rst_i low at BUSY cycle 10 of MUL -> valid_o=0 and ready_o=1 after
//      release. flush_i at DIV cycle 5 -> IDLE next edge, no valid_o.
//   6. SRA 0x80000000,4 -> 0xF8000000; SLL 1,33 -> 2 (amount masked to 1);
//      opcode 1111 on 3,4 -> 7.

Source files
------------

// File: rtl/alu_multicycle.sv
// -----------------------------------------------------------------------------
// alu_multicycle
//   Execute-stage ALU with valid/ready handshakes on both sides. Logic, add/sub
//   and shift ops complete on the edge after acceptance. MUL (low WIDTH bits),
//   DIVU and REMU run iteratively, one bit per cycle. The result appears
//   exactly WIDTH+1 edges after acceptance.
//
// Ports
//   clk_i      clock, rising edge
//   rst_i      asynchronous active-low reset
//   flush_i    synchronous abort of the op in flight or of the held result
//   valid_i    request valid
//   ready_o    request accepted on this edge when valid_i is also high
//   data1_i    operand A
//   data2_i    operand B (shifts use only the low SHW bits)
//   ALUCtrl_i  opcode, captured on acceptance
//   valid_o    result valid, held until ready_i or flush_i
//   ready_i    consumer takes the result
//   data_o     result, stable while valid_o is high
//   Zero_o     1 iff the captured operands were equal
// -----------------------------------------------------------------------------
module alu_multicycle #(
  parameter int WIDTH  = 32,
  parameter int CTRL_W = 4
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              flush_i,
  input  logic              valid_i,
  output logic              ready_o,
  input  logic [WIDTH-1:0]  data1_i,
  input  logic [WIDTH-1:0]  data2_i,
  input  logic [CTRL_W-1:0] ALUCtrl_i,
  output logic              valid_o,
  input  logic              ready_i,
  output logic [WIDTH-1:0]  data_o,
  output logic              Zero_o
);

  localparam int SHW   = $clog2(WIDTH);
  localparam int CNT_W = $clog2(WIDTH + 1);

  localparam logic [CTRL_W-1:0] OP_SUB  = CTRL_W'(1);
  localparam logic [CTRL_W-1:0] OP_MUL  = CTRL_W'(2);
  localparam logic [CTRL_W-1:0] OP_AND  = CTRL_W'(3);
  localparam logic [CTRL_W-1:0] OP_OR   = CTRL_W'(4);
  localparam logic [CTRL_W-1:0] OP_XOR  = CTRL_W'(5);
  localparam logic [CTRL_W-1:0] OP_SLL  = CTRL_W'(6);
  localparam logic [CTRL_W-1:0] OP_SRL  = CTRL_W'(7);
  localparam logic [CTRL_W-1:0] OP_SRA  = CTRL_W'(8);
  localparam logic [CTRL_W-1:0] OP_DIVU = CTRL_W'(9);
  localparam logic [CTRL_W-1:0] OP_REMU = CTRL_W'(10);

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUSY,
    S_DONE
  } state_t;

  state_t              state_q, state_d;
  logic [CTRL_W-1:0]   op_q,    op_d;
  // MUL: opb = shifting multiplicand, quo = shifting multiplier, acc = product.
  // DIV: opb = divisor, quo = dividend shifting into quotient, acc = remainder.
  logic [WIDTH-1:0]    opb_q,   opb_d;
  logic [WIDTH-1:0]    quo_q,   quo_d;
  logic [WIDTH-1:0]    acc_q,   acc_d;
  logic [CNT_W-1:0]    cnt_q,   cnt_d;
  logic [WIDTH-1:0]    res_q,   res_d;
  logic                zero_q,  zero_d;

  logic                accept;
  logic                is_iter;
  logic [WIDTH:0]      rem_sh;
  logic [WIDTH:0]      diff;

  // Single-cycle datapath; unlisted opcodes fall through to ADD.
  function automatic logic [WIDTH-1:0] simple_op(
    input logic [CTRL_W-1:0] op,
    input logic [WIDTH-1:0]  a,
    input logic [WIDTH-1:0]  b
  );
    logic [SHW-1:0]          sh;
    logic signed [WIDTH-1:0] sa;
    sh = b[SHW-1:0];
    sa = a;
    case (op)
      OP_SUB:  simple_op = a - b;
      OP_AND:  simple_op = a & b;
      OP_OR:   simple_op = a | b;
      OP_XOR:  simple_op = a ^ b;
      OP_SLL:  simple_op = a << sh;
      OP_SRL:  simple_op = a >> sh;
      OP_SRA:  simple_op = sa >>> sh;
      default: simple_op = a + b;
    endcase
  endfunction

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    opb_d   = opb_q;
    quo_d   = quo_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    res_d   = res_q;
    zero_d  = zero_q;

    ready_o = !flush_i && ((state_q == S_IDLE) || ((state_q == S_DONE) && ready_i));
    accept  = valid_i && ready_o;
    is_iter = (ALUCtrl_i == OP_MUL) || (ALUCtrl_i == OP_DIVU) || (ALUCtrl_i == OP_REMU);

    // Restoring-division step: shift the next dividend bit into the partial
    // remainder and subtract the divisor; a zero divisor never borrows, which
    // yields an all-ones quotient and leaves the dividend as the remainder.
    rem_sh  = {acc_q, quo_q[WIDTH-1]};
    diff    = rem_sh - {1'b0, opb_q};

    case (state_q)
      S_BUSY: begin
        if (cnt_q == '0) begin
          state_d = S_DONE;
          res_d   = (op_q == OP_DIVU) ? quo_q : acc_q;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
          if (op_q == OP_MUL) begin
            if (quo_q[0]) acc_d = acc_q + opb_q;
            opb_d = opb_q << 1;
            quo_d = quo_q >> 1;
          end else if (!diff[WIDTH]) begin
            acc_d = diff[WIDTH-1:0];
            quo_d = {quo_q[WIDTH-2:0], 1'b1};
          end else begin
            acc_d = rem_sh[WIDTH-1:0];
            quo_d = {quo_q[WIDTH-2:0], 1'b0};
          end
        end
      end
      S_DONE: begin
        if (ready_i) state_d = S_IDLE;
      end
      default: ;
    endcase

    // A new accept overrides the DONE->IDLE consume so back-to-back ops
    // need no bubble cycle.
    if (accept) begin
      zero_d = (data1_i == data2_i);
      if (is_iter) begin
        state_d = S_BUSY;
        op_d    = ALUCtrl_i;
        cnt_d   = CNT_W'(WIDTH);
        acc_d   = '0;
        if (ALUCtrl_i == OP_MUL) begin
          opb_d = data1_i;
          quo_d = data2_i;
        end else begin
          opb_d = data2_i;
          quo_d = data1_i;
        end
      end else begin
        state_d = S_DONE;
        res_d   = simple_op(ALUCtrl_i, data1_i, data2_i);
      end
    end

    if (flush_i) state_d = S_IDLE;
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= S_IDLE;
      op_q    <= '0;
      opb_q   <= '0;
      quo_q   <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      res_q   <= '0;
      zero_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      opb_q   <= opb_d;
      quo_q   <= quo_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      res_q   <= res_d;
      zero_q  <= zero_d;
    end
  end

  assign valid_o = (state_q == S_DONE);
  assign data_o  = res_q;
  assign Zero_o  = zero_q;

endmodule

// File: tb/tb_alu_multicycle.sv
// -----------------------------------------------------------------------------
// tb_alu_multicycle
//   Scoreboard bench for alu_multicycle (WIDTH=32). The driver pushes the
//   reference result of every accepted request; a monitor pops and compares
//   each time a result is consumed. Directed sections cover latency, stalls,
//   back-to-back issue, reset and flush; a randomized section follows.
// -----------------------------------------------------------------------------
module tb_alu_multicycle;

  logic        clk = 1'b0;
  logic        rst_i;
  logic        flush_i;
  logic        valid_i;
  logic        ready_o;
  logic [31:0] data1_i;
  logic [31:0] data2_i;
  logic [3:0]  ALUCtrl_i;
  logic        valid_o;
  logic        ready_i;
  logic [31:0] data_o;
  logic        Zero_o;

  int checks = 0;
  int errors = 0;

  logic [31:0] exp_d[$];
  logic        exp_z[$];

  always #5 clk = ~clk;

  alu_multicycle #(.WIDTH(32), .CTRL_W(4)) dut (
    .clk_i     (clk),
    .rst_i     (rst_i),
    .flush_i   (flush_i),
    .valid_i   (valid_i),
    .ready_o   (ready_o),
    .data1_i   (data1_i),
    .data2_i   (data2_i),
    .ALUCtrl_i (ALUCtrl_i),
    .valid_o   (valid_o),
    .ready_i   (ready_i),
    .data_o    (data_o),
    .Zero_o    (Zero_o)
  );

  // Reference model: plain arithmetic on the opcode table.
  function automatic logic [31:0] ref_result(input logic [3:0] op,
                                             input logic [31:0] a,
                                             input logic [31:0] b);
    logic [4:0] sh;
    sh = b[4:0];
    case (op)
      4'd1:    return a - b;
      4'd2:    return a * b;
      4'd3:    return a & b;
      4'd4:    return a | b;
      4'd5:    return a ^ b;
      4'd6:    return a << sh;
      4'd7:    return a >> sh;
      4'd8:    return $signed(a) >>> sh;
      4'd9:    return (b == 0) ? 32'hFFFF_FFFF : a / b;
      4'd10:   return (b == 0) ? a : a % b;
      default: return a + b;
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge following the accept edge.
  task automatic send(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    int n = 0;
    valid_i   = 1'b1;
    ALUCtrl_i = op;
    data1_i   = a;
    data2_i   = b;
    #1;
    while (!ready_o && n < 200) begin
      @(negedge clk); #1; n++;
    end
    if (!ready_o) begin
      check1("accept_timeout", ready_o, 1'b1);
    end else begin
      exp_d.push_back(ref_result(op, a, b));
      exp_z.push_back(a == b);
    end
    @(posedge clk); #1;
    valid_i   = 1'b0;
    data1_i   = $urandom;
    data2_i   = $urandom;
    ALUCtrl_i = 4'($urandom);
    @(negedge clk);
  endtask

  task automatic drain();
    int n = 0;
    while (exp_d.size() != 0 && n < 200) begin
      @(negedge clk); n++;
    end
    check("drain_pending", exp_d.size(), 0);
  endtask

  // Monitor: a result is consumed on the next edge when valid_o && ready_i.
  initial begin
    logic [31:0] d;
    logic        z;
    forever begin
      @(negedge clk); #3;
      if (rst_i && valid_o && ready_i && !flush_i) begin
        if (exp_d.size() == 0) begin
          check1("unexpected_valid", valid_o, 1'b0);
        end else begin
          d = exp_d.pop_front();
          z = exp_z.pop_front();
          check("result", data_o, d);
          check1("zero", Zero_o, z);
        end
      end
    end
  end

  initial begin
    int n;
    bit busy_ok;
    logic [3:0]  op;
    logic [31:0] a, b;

    rst_i = 1'b0; flush_i = 1'b0; valid_i = 1'b0; ready_i = 1'b1;
    data1_i = '0; data2_i = '0; ALUCtrl_i = '0;
    repeat (3) @(negedge clk);
    check1("reset_valid", valid_o, 1'b0);
    check("reset_data", data_o, 32'h0);
    check1("reset_zero", Zero_o, 1'b0);
    rst_i = 1'b1;
    @(negedge clk); #1;
    check1("ready_after_reset", ready_o, 1'b1);
    @(negedge clk);

    // ADD / SUB with zero flag
    send(4'd0, 32'd5, 32'd7);
    check1("add_valid_next_edge", valid_o, 1'b1);
    check("add_data", data_o, 32'd12);
    send(4'd1, 32'd9, 32'd9);
    check1("sub_zero", Zero_o, 1'b1);

    // MUL latency and ready_o low during BUSY
    send(4'd2, 32'h0000_FFFF, 32'h0001_0001);
    n = 0; busy_ok = 1'b1;
    while (!valid_o && n < 60) begin
      @(posedge clk); #1; n++;
      if (!valid_o && ready_o) busy_ok = 1'b0;
    end
    check("mul_latency", n, 32'd33);
    check1("busy_ready_low", busy_ok, 1'b1);
    check("mul_data", data_o, 32'hFFFF_FFFF);
    @(negedge clk);

    // Division, including divide-by-zero
    send(4'd9,  32'd100, 32'd7);
    send(4'd10, 32'd100, 32'd7);
    send(4'd9,  32'd9,   32'd0);
    send(4'd10, 32'd9,   32'd0);
    drain();

    // Shifts and unused opcode
    send(4'd8,  32'h8000_0000, 32'd4);
    send(4'd6,  32'd1,         32'd33);
    send(4'd15, 32'd3,         32'd4);
    send(4'd3,  32'hF0F0_1234, 32'h0FF0_FF00);
    send(4'd4,  32'hF000_0000, 32'h0000_000F);
    send(4'd5,  32'hAAAA_5555, 32'hFFFF_0000);
    send(4'd7,  32'h8000_0000, 32'd31);
    drain();

    // Stall in DONE, then consume and accept on the same edge
    ready_i = 1'b0;
    send(4'd0, 32'd20, 32'd22);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); #1;
      check("stall_data", data_o, 32'd42);
      check1("stall_ready", ready_o, 1'b0);
    end
    ready_i = 1'b1;
    send(4'd0, 32'd1, 32'd1);
    check1("b2b_valid", valid_o, 1'b1);
    check("b2b_data", data_o, 32'd2);
    drain();

    // Reset during MUL BUSY
    send(4'd2, 32'd1234, 32'd5678);
    repeat (9) @(negedge clk);
    rst_i = 1'b0;
    #2;
    check1("midbusy_reset_valid", valid_o, 1'b0);
    check("midbusy_reset_data", data_o, 32'h0);
    @(negedge clk);
    rst_i = 1'b1;
    exp_d.delete(); exp_z.delete();
    #1;
    check1("midbusy_ready", ready_o, 1'b1);
    busy_ok = 1'b1;
    repeat (40) begin @(negedge clk); #1; if (valid_o) busy_ok = 1'b0; end
    check1("no_valid_after_reset", busy_ok, 1'b1);

    // Flush during DIV BUSY
    send(4'd9, 32'd1000, 32'd3);
    repeat (4) @(negedge clk);
    flush_i = 1'b1;
    #1;
    check1("flush_ready", ready_o, 1'b0);
    @(posedge clk); #1;
    check1("flush_valid", valid_o, 1'b0);
    @(negedge clk);
    flush_i = 1'b0;
    exp_d.delete(); exp_z.delete();
    busy_ok = 1'b1;
    repeat (40) begin @(negedge clk); #1; if (valid_o) busy_ok = 1'b0; end
    check1("no_valid_after_flush", busy_ok, 1'b1);
    @(negedge clk);
    send(4'd1, 32'd10, 32'd3);
    drain();

    // Randomized traffic with stalls and back-to-back issue
    for (int i = 0; i < 60; i++) begin
      op = 4'($urandom_range(0, 15));
      a  = $urandom;
      case ($urandom_range(0, 3))
        0:       b = 32'd0;
        1:       b = 32'($urandom_range(1, 40));
        2:       b = a;
        default: b = $urandom;
      endcase
      send(op, a, b);
      if ($urandom_range(0, 3) == 0) begin
        ready_i = 1'b0;
        repeat ($urandom_range(1, 4)) @(negedge clk);
        ready_i = 1'b1;
      end
      repeat ($urandom_range(0, 1)) @(negedge clk);
    end
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
